// File: rtl/ise_ctrl_if.sv
// ise_ctrl_if
// Groups the pixel-input handshake, the datapath control/status lines and
// the result bus of the ise_ctrl image sorting controller.
//   in_valid, image_in_index    : pixel stream qualifier and image number
//   busy, pix_en                : pixel acceptance status and accumulate strobe
//   cls_start, cls_done         : classification request / result handshake
//   cls_color, acc_clr          : classification colour, accumulator clear
//   out_valid, color_index,
//   image_out_index             : sorted result stream
// The slave modport is the controller's view; master is the driver's view.
interface ise_ctrl_if;
   logic       in_valid;
   logic [4:0] image_in_index;
   logic       cls_done;
   logic [1:0] cls_color;
   logic       busy;
   logic       pix_en;
   logic       cls_start;
   logic       acc_clr;
   logic       out_valid;
   logic [1:0] color_index;
   logic [4:0] image_out_index;

   modport master (
      output in_valid, image_in_index, cls_done, cls_color,
      input  busy, pix_en, cls_start, acc_clr, out_valid, color_index, image_out_index
   );

   modport slave (
      input  in_valid, image_in_index, cls_done, cls_color,
      output busy, pix_en, cls_start, acc_clr, out_valid, color_index, image_out_index
   );
endinterface

// File: rtl/ise_ctrl.sv
// ise_ctrl
// Controller for a batch image colour sorter. Pixels of one image are
// counted while the external datapath accumulates them; after the last
// pixel the datapath is asked to classify the image, the returned colour is
// stored in a per-index table, and once IMAGE_NUM images have been seen the
// table is scanned three times (red, green, blue) emitting matching image
// indices in ascending order.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-low
//   bus   : ise_ctrl_if.slave (pixel input, datapath control, result stream)
module ise_ctrl #(
   parameter int IMAGE_NUM  = 32,
   parameter int IMAGE_SIZE = 128
) (
   input logic       clk,
   input logic       reset,
   ise_ctrl_if.slave bus
);

   localparam int PIX_NUM = IMAGE_SIZE * IMAGE_SIZE;
   localparam int PIX_W   = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_NUM - 1);
   localparam logic [5:0]       IMG_TOTAL = 6'(IMAGE_NUM);
   localparam logic [4:0]       IDX_LAST  = 5'(IMAGE_NUM - 1);

   typedef enum logic [1:0] {LOAD, CLS, CLR, OUT} state_t;

   state_t            state_q, state_d;
   logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic [4:0]        img_idx_q, img_idx_d;
   logic [5:0]        img_cnt_q, img_cnt_d;
   logic [31:0]       valid_q, valid_d;
   logic [31:0][1:0]  color_q, color_d;
   logic [1:0]        pass_q, pass_d;
   logic [4:0]        idx_q, idx_d;
   logic              cls_start_q, cls_start_d;
   logic              out_valid_q, out_valid_d;
   logic [1:0]        color_index_q, color_index_d;
   logic [4:0]        image_out_index_q, image_out_index_d;

   logic              busy;
   logic              pix_en;
   logic              scan_hit;

   // Pixels are only accepted while loading; busy is a pure decode of the
   // state register so it never glitches with the inputs.
   assign busy   = (state_q != LOAD);
   assign pix_en = bus.in_valid & ~busy;

   assign bus.busy            = busy;
   assign bus.pix_en          = pix_en;
   assign bus.cls_start       = cls_start_q;
   assign bus.acc_clr         = (state_q == CLR);
   assign bus.out_valid       = out_valid_q;
   assign bus.color_index     = color_index_q;
   assign bus.image_out_index = image_out_index_q;

   // Next-state and datapath control. Every register holds by default; each
   // state only touches what it owns. The scan emits its result one cycle
   // late through out_valid_q, so the last match of a batch shows up in the
   // first LOAD cycle of the next one.
   always_comb begin
      state_d           = state_q;
      pix_cnt_d         = pix_cnt_q;
      img_idx_d         = img_idx_q;
      img_cnt_d         = img_cnt_q;
      valid_d           = valid_q;
      color_d           = color_q;
      pass_d            = pass_q;
      idx_d             = idx_q;
      cls_start_d       = 1'b0;
      out_valid_d       = 1'b0;
      color_index_d     = color_index_q;
      image_out_index_d = image_out_index_q;
      scan_hit          = valid_q[idx_q] && (color_q[idx_q] == pass_q);

      case (state_q)
         LOAD: begin
            if (pix_en) begin
               // The image number is taken from the first pixel only.
               if (pix_cnt_q == '0) begin
                  img_idx_d = bus.image_in_index;
               end
               if (pix_cnt_q == PIX_LAST) begin
                  pix_cnt_d   = '0;
                  cls_start_d = 1'b1;
                  state_d     = CLS;
               end else begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
         end

         CLS: begin
            // Colour code 3 is not a legal class; it folds into blue.
            if (bus.cls_done) begin
               valid_d[img_idx_q] = 1'b1;
               color_d[img_idx_q] = (bus.cls_color == 2'd3) ? 2'd2 : bus.cls_color;
               state_d            = CLR;
            end
         end

         CLR: begin
            img_cnt_d = img_cnt_q + 6'd1;
            state_d   = (img_cnt_q + 6'd1 == IMG_TOTAL) ? OUT : LOAD;
         end

         OUT: begin
            if (scan_hit) begin
               out_valid_d       = 1'b1;
               color_index_d     = pass_q;
               image_out_index_d = idx_q;
            end
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               if (pass_q == 2'd2) begin
                  pass_d    = '0;
                  valid_d   = '0;
                  img_cnt_d = '0;
                  state_d   = LOAD;
               end else begin
                  pass_d = pass_q + 2'd1;
               end
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end

         default: state_d = LOAD;
      endcase
   end

   // State register. Reset abandons any batch in flight, including the
   // classification table, so nothing stale can be emitted afterwards.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q           <= LOAD;
         pix_cnt_q         <= '0;
         img_idx_q         <= '0;
         img_cnt_q         <= '0;
         valid_q           <= '0;
         color_q           <= '0;
         pass_q            <= '0;
         idx_q             <= '0;
         cls_start_q       <= 1'b0;
         out_valid_q       <= 1'b0;
         color_index_q     <= '0;
         image_out_index_q <= '0;
      end else begin
         state_q           <= state_d;
         pix_cnt_q         <= pix_cnt_d;
         img_idx_q         <= img_idx_d;
         img_cnt_q         <= img_cnt_d;
         valid_q           <= valid_d;
         color_q           <= color_d;
         pass_q            <= pass_d;
         idx_q             <= idx_d;
         cls_start_q       <= cls_start_d;
         out_valid_q       <= out_valid_d;
         color_index_q     <= color_index_d;
         image_out_index_q <= image_out_index_d;
      end
   end

endmodule

// File: tb/tb_ise_ctrl.sv
// tb_ise_ctrl
// Bench for ise_ctrl using a small image size so whole batches run quickly.
// A table of per-index colours is kept as the expected picture of the
// controller, and the three-pass sorted output is derived from it directly.
module tb_ise_ctrl;

   localparam int IMAGE_NUM  = 32;
   localparam int IMAGE_SIZE = 4;
   localparam int PIX        = IMAGE_SIZE * IMAGE_SIZE;
   localparam int SCAN_LEN   = 3 * IMAGE_NUM;

   logic clk;
   logic reset;

   ise_ctrl_if bus ();

   ise_ctrl #(
      .IMAGE_NUM  (IMAGE_NUM),
      .IMAGE_SIZE (IMAGE_SIZE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checkCount = 0;
   int passCount  = 0;
   int expCount   = 0;

   bit         mValid [IMAGE_NUM];
   logic [1:0] mColor [IMAGE_NUM];
   logic [1:0] lastColor;
   logic [4:0] lastIdx;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                    tag, observed, expected, $time);
   endtask

   task automatic clearModel(input bit clearLast);
      for (int i = 0; i < IMAGE_NUM; i++) mValid[i] = 1'b0;
      if (clearLast) begin
         lastColor = 2'd0;
         lastIdx   = 5'd0;
      end
   endtask

   // Two reset cycles; the outputs are looked at while reset is still low.
   task automatic doReset();
      reset         = 1'b0;
      bus.cls_done  = 1'b0;
      bus.in_valid  = 1'b0;
      tick();
      bus.in_valid = 1'b1;
      #1;
      checkOutput("rstBusy",     bus.busy, 0);
      checkOutput("rstClsStart", bus.cls_start, 0);
      checkOutput("rstAccClr",   bus.acc_clr, 0);
      checkOutput("rstOutBus",   {bus.out_valid, bus.color_index, bus.image_out_index}, 0);
      checkOutput("rstPixEn1",   bus.pix_en, 1);
      tick();
      bus.in_valid = 1'b0;
      #1;
      checkOutput("rstPixEn0", bus.pix_en, 0);
      reset = 1'b1;
      clearModel(1'b1);
   endtask

   // Streams one image with random gaps and stray cls_done pulses, then
   // answers the classification request after a random delay.
   task automatic applyStimulus(input logic [4:0] idx, input logic [1:0] colour,
                                input bit lastImg);
      int p;
      int waitCyc;
      p = 0;
      while (p < PIX) begin
         bus.in_valid       = ($urandom_range(0, 3) != 0);
         bus.image_in_index = (bus.in_valid && p == 0) ? idx : 5'($urandom_range(0, 31));
         bus.cls_done       = ($urandom_range(0, 7) == 0);
         bus.cls_color      = 2'($urandom_range(0, 3));
         #1;
         checkOutput("pixEn",     bus.pix_en, bus.in_valid);
         checkOutput("busyLoad",  bus.busy, 0);
         checkOutput("clsStart0", bus.cls_start, 0);
         checkOutput("accClr0",   bus.acc_clr, 0);
         checkOutput("outIdle",   bus.out_valid, 0);
         if (bus.in_valid) p++;
         tick();
      end
      bus.cls_done       = 1'b0;
      bus.in_valid       = 1'b1;
      bus.image_in_index = 5'($urandom_range(0, 31));
      #1;
      checkOutput("clsStart1", bus.cls_start, 1);
      checkOutput("busyCls",   bus.busy, 1);
      checkOutput("pixEnCls",  bus.pix_en, 0);
      waitCyc = $urandom_range(0, 3);
      repeat (waitCyc) begin
         tick();
         checkOutput("clsStartOnce", bus.cls_start, 0);
         checkOutput("busyClsWait",  bus.busy, 1);
         checkOutput("pixEnWait",    bus.pix_en, 0);
      end
      bus.cls_done  = 1'b1;
      bus.cls_color = colour;
      tick();
      bus.cls_done = 1'b0;
      mValid[idx]  = 1'b1;
      mColor[idx]  = (colour == 2'd3) ? 2'd2 : colour;
      checkOutput("accClr1", bus.acc_clr, 1);
      checkOutput("busyClr", bus.busy, 1);
      bus.in_valid = 1'b0;
      tick();
      checkOutput("accClrOnce", bus.acc_clr, 0);
      checkOutput("busyAfter",  bus.busy, lastImg);
   endtask

   // Expected outcome of scan position q: pass q/IMAGE_NUM over index
   // q%IMAGE_NUM; a match also becomes the held output value.
   task automatic modelScan(input int q, output bit hit);
      int passNo;
      int i;
      passNo = q / IMAGE_NUM;
      i      = q % IMAGE_NUM;
      hit    = mValid[i] && (mColor[i] == 2'(passNo));
      if (hit) begin
         lastColor = 2'(passNo);
         lastIdx   = 5'(i);
         expCount++;
      end
   endtask

   // Walks the output phase cycle by cycle; abortAt >= 0 pulses reset
   // during that scan position.
   task automatic runOut(input int abortAt);
      bit hit;
      int seen;
      seen     = 0;
      expCount = 0;
      for (int c = 0; c <= SCAN_LEN; c++) begin
         hit = 1'b0;
         if (c > 0) modelScan(c - 1, hit);
         if (c < SCAN_LEN) begin
            bus.in_valid       = 1'($urandom_range(0, 1));
            bus.image_in_index = 5'($urandom_range(0, 31));
            bus.cls_done       = 1'($urandom_range(0, 1));
            bus.cls_color      = 2'($urandom_range(0, 3));
         end else begin
            bus.in_valid = 1'b0;
            bus.cls_done = 1'b0;
         end
         #1;
         checkOutput("outBus",   {bus.out_valid, bus.color_index, bus.image_out_index},
                     {hit, lastColor, lastIdx});
         checkOutput("busyOut",  bus.busy, (c < SCAN_LEN));
         checkOutput("pixEnOut", bus.pix_en, 0);
         checkOutput("accClrOut", bus.acc_clr, 0);
         if (bus.out_valid) seen++;
         if (c == abortAt) begin
            reset = 1'b0;
            tick();
            reset        = 1'b1;
            bus.in_valid = 1'b0;
            bus.cls_done = 1'b0;
            #1;
            checkOutput("abortBus", {bus.busy, bus.out_valid, bus.color_index,
                                     bus.image_out_index}, 0);
            clearModel(1'b1);
            repeat (3) begin
               tick();
               checkOutput("abortQuiet", bus.out_valid, 0);
            end
            return;
         end
         if (c < SCAN_LEN) tick();
      end
      checkOutput("pulseCount", seen, expCount);
      clearModel(1'b0);
      tick();
      checkOutput("outDrop", bus.out_valid, 0);
   endtask

   // mode 0: index i colour i%3; mode 1: random indices and colours;
   // mode 2: image 7 repeated (colour 0 then 2), image 12 missing.
   task automatic runBatch(input int mode, input int abortAt);
      logic [4:0] idx;
      logic [1:0] col;
      for (int i = 0; i < IMAGE_NUM; i++) begin
         case (mode)
            0: begin
               idx = 5'(i);
               col = 2'(i % 3);
            end
            1: begin
               idx = 5'($urandom_range(0, IMAGE_NUM - 1));
               col = 2'($urandom_range(0, 3));
            end
            default: begin
               if (i == 12) begin
                  idx = 5'd7;
                  col = 2'd2;
               end else begin
                  idx = 5'(i);
                  col = (i == 7) ? 2'd0 : 2'(i % 3);
               end
            end
         endcase
         applyStimulus(idx, col, i == IMAGE_NUM - 1);
      end
      runOut(abortAt);
   endtask

   // Feeds nPix pixels of an image and then resets, abandoning it.
   task automatic partialImage(input int nPix);
      for (int p = 0; p < nPix; p++) begin
         bus.in_valid       = 1'b1;
         bus.image_in_index = (p == 0) ? 5'd20 : 5'($urandom_range(0, 31));
         bus.cls_done       = 1'($urandom_range(0, 1));
         bus.cls_color      = 2'($urandom_range(0, 3));
         #1;
         checkOutput("partPixEn",    bus.pix_en, 1);
         checkOutput("partClsStart", bus.cls_start, 0);
         tick();
      end
      doReset();
   endtask

   initial begin
      reset              = 1'b0;
      bus.in_valid       = 1'b0;
      bus.image_in_index = 5'd0;
      bus.cls_done       = 1'b0;
      bus.cls_color      = 2'd0;
      lastColor          = 2'd0;
      lastIdx            = 5'd0;
      clearModel(1'b1);
      $display("[TB] start");
      doReset();
      runBatch(0, -1);
      runBatch(2, -1);
      partialImage(PIX / 2);
      runBatch(1, -1);
      partialImage(PIX);
      runBatch(1, IMAGE_NUM + 10);
      runBatch(1, -1);
      runBatch(0, -1);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
